// File: rtl/counter_share_arbiter.sv
// rtl/counter_share_arbiter.sv - round-robin arbiter sharing one wrap-around up/down/load counter
// Two-state sequencer: IDLE grants and latches one client's op, EXEC applies it and acks.
module counter_share_arbiter #(
  parameter int                    WORD_WIDTH    = 16,
  parameter int                    REQUESTERS    = 4,
  parameter logic [WORD_WIDTH-1:0] INITIAL_COUNT = '0
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [REQUESTERS-1:0]              req,
  input  logic [REQUESTERS-1:0]              up_down,
  input  logic [REQUESTERS-1:0]              wren,
  input  logic [REQUESTERS*WORD_WIDTH-1:0]   write_data,
  output logic [REQUESTERS-1:0]              ack,
  output logic [$clog2(REQUESTERS)-1:0]      grant_id,
  output logic                               busy,
  output logic [WORD_WIDTH-1:0]              count,
  output logic                               zero,
  output logic                               wrapped
);
  localparam int IW = $clog2(REQUESTERS);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                  state_q;
  logic [IW-1:0]           rr_q, idx_q, grant_q;
  logic                    up_q, wren_q, wrapped_q;
  logic [WORD_WIDTH-1:0]   data_q, count_q, count_d;
  logic [REQUESTERS-1:0]   ack_q, eligible;
  logic                    wrap_d, sel_found;
  logic [IW-1:0]           sel_idx, cand_idx;
  int                      cand;
  logic [WORD_WIDTH-1:0]   wdata [REQUESTERS];

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
    assign wdata[gi] = write_data[gi*WORD_WIDTH +: WORD_WIDTH];
  end

  // The client acked this cycle is masked so a one-cycle-late req drop cannot re-grant it.
  always_comb begin
    eligible  = req & ~ack_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand     = (int'(rr_q) + k) % REQUESTERS;
      cand_idx = IW'(cand);
      if (!sel_found && eligible[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (wren_q) begin
      count_d = data_q;
    end else if (up_q) begin
      count_d = count_q + WORD_WIDTH'(1);
      wrap_d  = &count_q;
    end else begin
      count_d = count_q - WORD_WIDTH'(1);
      wrap_d  = (count_q == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      up_q      <= 1'b0;
      wren_q    <= 1'b0;
      data_q    <= '0;
      count_q   <= INITIAL_COUNT;
      ack_q     <= '0;
      wrapped_q <= 1'b0;
    end else begin
      ack_q     <= '0;
      wrapped_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            idx_q   <= sel_idx;
            grant_q <= sel_idx;
            up_q    <= up_down[sel_idx];
            wren_q  <= wren[sel_idx];
            data_q  <= wdata[sel_idx];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          count_q   <= count_d;
          wrapped_q <= wrap_d;
          ack_q     <= REQUESTERS'(1) << idx_q;
          rr_q      <= (idx_q == IW'(REQUESTERS - 1)) ? '0 : idx_q + IW'(1);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == EXEC);
  assign count    = count_q;
  assign zero     = (count_q == '0);
  assign wrapped  = wrapped_q;
endmodule

// File: tb/tb_counter_share_arbiter.sv
// tb/tb_counter_share_arbiter.sv - random and directed check of counter_share_arbiter against a behavioural model
module tb_counter_share_arbiter;
  localparam int          R    = 4;
  localparam logic [15:0] INIT = 16'd5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0, up_down = '0, wren = '0;
  logic [63:0] write_data = '0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy, zero, wrapped;
  logic [15:0] count;

  int vectors = 0;
  int miscompares = 0;

  counter_share_arbiter #(
    .WORD_WIDTH(16), .REQUESTERS(R), .INITIAL_COUNT(INIT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .up_down(up_down), .wren(wren),
    .write_data(write_data), .ack(ack), .grant_id(grant_id), .busy(busy),
    .count(count), .zero(zero), .wrapped(wrapped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one pending op at a time, count kept as a plain integer.
  int         m_count, m_idx, m_rr, m_grant, m_data, m_sum, m_j;
  bit         m_busy, m_up, m_wren, m_wrapped;
  logic [3:0] m_ack, m_prev;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_count = int'(INIT); m_idx = 0; m_rr = 0; m_grant = 0; m_data = 0;
      m_busy = 0; m_up = 0; m_wren = 0; m_wrapped = 0; m_ack = '0; m_prev = '0;
    end else begin
      m_prev    = m_ack;
      m_ack     = '0;
      m_wrapped = 0;
      if (m_busy) begin
        if (m_wren) begin
          m_count = m_data;
        end else begin
          m_sum     = m_count + (m_up ? 1 : -1);
          m_wrapped = (m_sum < 0) || (m_sum > 65535);
          m_count   = (m_sum + 65536) % 65536;
        end
        m_ack[m_idx] = 1'b1;
        m_rr         = (m_idx + 1) % R;
        m_busy       = 0;
      end else begin
        for (int k = 0; k < R; k++) begin
          m_j = (m_rr + k) % R;
          if (!m_busy && req[m_j] && !m_prev[m_j]) begin
            m_busy  = 1;
            m_idx   = m_j;
            m_grant = m_j;
            m_up    = up_down[m_j];
            m_wren  = wren[m_j];
            m_data  = int'(write_data[m_j*16 +: 16]);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("ack", ack, m_ack);
      chk("grant_id", grant_id, m_grant[1:0]);
      chk("busy", busy, m_busy);
      chk("count", count, m_count[15:0]);
      chk("zero", zero, m_count == 0);
      chk("wrapped", wrapped, m_wrapped);
    end
  end

  task automatic run_op(input int i, input bit up, input bit wr, input logic [15:0] d,
                        output logic [1:0] g, output logic b, output logic [3:0] a,
                        output logic [15:0] c, output logic w);
    req[i] = 1'b1; up_down[i] = up; wren[i] = wr; write_data[i*16 +: 16] = d;
    @(negedge clock);
    g = grant_id; b = busy;
    @(negedge clock);
    a = ack; c = count; w = wrapped;
    req[i] = 1'b0;
    @(negedge clock);
  endtask

  logic [1:0]  g;
  logic        b, w;
  logic [3:0]  a, late;
  logic [15:0] c;
  int          ack_at[$], ack_who[$];

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_count", count, 16'd5);
    chk("reset_ack", ack, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_grant", grant_id, 2'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(2, 1'b1, 1'b0, 16'h0000, g, b, a, c, w);
    chk("t2_grant", g, 2'd2);
    chk("t2_busy", b, 1'b1);
    chk("t2_ack", a, 4'b0100);
    chk("t2_count", c, 16'd6);
    chk("t2_wrapped", w, 1'b0);

    run_op(1, 1'b1, 1'b1, 16'h1234, g, b, a, c, w);
    chk("t5_ack", a, 4'b0010);
    chk("t5_count", c, 16'h1234);
    chk("t5_wrapped", w, 1'b0);

    run_op(3, 1'b0, 1'b1, 16'hFFFF, g, b, a, c, w);
    chk("t3_load", c, 16'hFFFF);
    run_op(0, 1'b1, 1'b0, 16'h0000, g, b, a, c, w);
    chk("t3_up_count", c, 16'h0000);
    chk("t3_up_wrapped", w, 1'b1);
    chk("t3_zero", zero, 1'b1);
    run_op(2, 1'b0, 1'b0, 16'h0000, g, b, a, c, w);
    chk("t3_down_count", c, 16'hFFFF);
    chk("t3_down_wrapped", w, 1'b1);

    req[0] = 1'b1; up_down[0] = 1'b1; wren[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("t6_ack", ack, 4'b0001);
    chk("t6_count", count, 16'h0000);
    @(negedge clock);
    chk("t6_masked", ack, 4'b0000);
    req[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      chk("t6_no_reack", ack[0], 1'b0);
    end
    chk("t6_stepped_once", count, 16'h0000);

    req[1] = 1'b1; up_down[1] = 1'b1; wren[1] = 1'b0;
    @(negedge clock);
    chk("t1_busy_before_reset", busy, 1'b1);
    #2 reset_n = 1'b0; req = '0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("t1_count_after_abort", count, 16'd5);
    chk("t1_ack_after_abort", ack, 4'b0000);
    chk("t1_busy_after_abort", busy, 1'b0);
    @(negedge clock);
    chk("t1_no_late_ack", ack, 4'b0000);

    req = 4'hF; up_down = 4'hF; wren = 4'h0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      for (int i = 0; i < R; i++)
        if (ack[i]) begin
          ack_at.push_back(n);
          ack_who.push_back(i);
        end
    end
    req = '0;
    chk("t4_nacks", ack_at.size(), 5);
    for (int e = 0; e < 5; e++) begin
      if (e < ack_at.size()) begin
        chk("t4_order", ack_who[e], e % R);
        chk("t4_cycle", ack_at[e], 2 * (e + 1));
      end
    end
    repeat (3) @(negedge clock);

    late = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < R; i++) begin
        if (ack[i]) begin
          if ($urandom_range(1, 0) == 1) late[i] = 1'b1;
          else req[i] = 1'b0;
        end else if (late[i]) begin
          req[i]  = 1'b0;
          late[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          up_down[i] = 1'($urandom);
          wren[i]    = ($urandom_range(7, 0) == 0);
          case ($urandom_range(2, 0))
            0:       write_data[i*16 +: 16] = 16'h0000;
            1:       write_data[i*16 +: 16] = 16'hFFFF;
            default: write_data[i*16 +: 16] = 16'($urandom);
          endcase
          req[i] = 1'b1;
        end
      end
      @(negedge clock);
    end
    req = '0;
    repeat (4) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
